// File: rtl/aib_mac_tx_gen_pkg.sv
`default_nettype none
// ============================================================================
// aib_mac_tx_gen_pkg : shared types and constants for the AIB MAC TX generator
// Rev 1.0
// ============================================================================
package aib_mac_tx_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RDY       = 3'd1,
    ST_WAIT_XFER = 3'd2,
    ST_MARK      = 3'd3,
    ST_STREAM    = 3'd4,
    ST_DONE      = 3'd5
  } gen_state_e;

  localparam logic [1:0] MODE_CNT  = 2'd0;
  localparam logic [1:0] MODE_PRBS = 2'd1;
  localparam logic [1:0] MODE_WALK = 2'd2;
  localparam logic [1:0] MODE_ZERO = 2'd3;

  // x^31 + x^28 + 1 taps as bit indices of a left-shifting register
  localparam int          PRBS_TAP_A  = 30;
  localparam int          PRBS_TAP_B  = 27;
  localparam logic [30:0] PRBS31_SEED = 31'h7FFF_FFFF;

  function automatic logic [30:0] prbs31_step(input logic [30:0] s);
    return {s[29:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aib_prbs31_lfsr.sv
`default_nettype none
// ============================================================================
// aib_prbs31_lfsr : single-step PRBS31 register with seed load and advance
// Rev 1.0
// ============================================================================
module aib_prbs31_lfsr
  import aib_mac_tx_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  output logic [30:0] q
);

  logic [30:0] q_q;
  logic [30:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = PRBS31_SEED;
    end else if (adv) begin
      q_d = prbs31_step(q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/aib_mac_tx_gen.sv
`default_nettype none
// ============================================================================
// aib_mac_tx_gen : AIB MAC-side TX bring-up, marker preamble and payload gen
// Rev 1.0
// ============================================================================
module aib_mac_tx_gen
  import aib_mac_tx_gen_pkg::*;
#(
  parameter int DWIDTH     = 40,
  parameter int LOCK_CYC   = 16,
  parameter int MARK_WORDS = 8
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  gen_en,
  input  logic [1:0]            gen_mode,
  input  logic [15:0]           num_words,
  input  logic                  ms_tx_transfer_en,
  input  logic                  sl_rx_transfer_en,
  output logic                  ns_adapter_rstn,
  output logic                  ns_mac_rdy,
  output logic [2*DWIDTH-1:0]   data_in,
  output logic                  data_vld,
  output logic [15:0]           word_cnt,
  output logic                  done,
  output logic [2:0]            state
);

  localparam int PW = 2*DWIDTH - 1;
  localparam int WW = (PW > 1) ? $clog2(PW) : 1;

  gen_state_e        state_q, state_d;
  logic [7:0]        stab_q, stab_d, stab_nx;
  logic [7:0]        mark_q, mark_d;
  logic [15:0]       word_cnt_q, word_cnt_d, num_q, num_d, cur_cnt;
  logic [31:0]       idx_q, idx_d, cur_idx;
  logic [WW-1:0]     walk_q, walk_d, cur_walk;
  logic [1:0]        mode_q, mode_d, cur_mode;
  logic [2*DWIDTH-1:0] data_q, data_d;
  logic              vld_q, vld_d, done_q, done_d, rdy_q, rdy_d;
  logic              xfer, entry, lfsr_load, lfsr_adv;
  logic [30:0]       lfsr_q, cur_prbs;
  logic [PW-1:0]     payload;

  // LFSR state repeated from the LSB upward across the payload width
  function automatic logic [PW-1:0] prbs_payload(input logic [30:0] s);
    logic [PW-1:0] p;
    for (int i = 0; i < PW; i++) p[i] = s[i % 31];
    return p;
  endfunction

  assign xfer    = ms_tx_transfer_en & sl_rx_transfer_en;
  assign stab_nx = xfer ? stab_q + 8'd1 : 8'd0;

  aib_prbs31_lfsr u_lfsr (
    .clk  (wr_clk),
    .rst  (wr_rst),
    .load (lfsr_load),
    .adv  (lfsr_adv),
    .q    (lfsr_q)
  );

  always_ff @(posedge wr_clk) begin
    if (wr_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!gen_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_RDY;
        ST_RDY:       state_d = ST_WAIT_XFER;
        ST_WAIT_XFER: if (stab_nx == 8'(LOCK_CYC)) state_d = ST_MARK;
        ST_MARK: begin
          if (!xfer)                           state_d = ST_WAIT_XFER;
          else if (mark_q == 8'(MARK_WORDS))   state_d = ST_STREAM;
        end
        ST_STREAM: begin
          if (!xfer)                                      state_d = ST_WAIT_XFER;
          else if ((num_q != 16'd0) && (word_cnt_q == num_q)) state_d = ST_DONE;
        end
        ST_DONE:      state_d = ST_DONE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stab_d     = '0;
    mark_d     = '0;
    word_cnt_d = word_cnt_q;
    idx_d      = idx_q;
    walk_d     = walk_q;
    mode_d     = mode_q;
    num_d      = num_q;
    data_d     = '0;
    vld_d      = 1'b0;
    done_d     = 1'b0;
    rdy_d      = (state_d != ST_IDLE);
    lfsr_load  = 1'b0;
    lfsr_adv   = 1'b0;

    // First stream word is built from fresh values, later ones from state
    entry    = (state_q != ST_STREAM);
    cur_mode = entry ? gen_mode : mode_q;
    cur_idx  = entry ? 32'd0    : idx_q;
    cur_walk = entry ? '0       : walk_q;
    cur_cnt  = entry ? 16'd0    : word_cnt_q;
    cur_prbs = entry ? PRBS31_SEED : prbs31_step(lfsr_q);

    payload = '0;
    case (cur_mode)
      MODE_CNT:  payload = PW'(cur_idx);
      MODE_PRBS: payload = prbs_payload(cur_prbs);
      MODE_WALK: payload = {{(PW-1){1'b0}}, 1'b1} << cur_walk;
      default:   payload = '0;
    endcase

    case (state_d)
      ST_IDLE:      word_cnt_d = '0;
      ST_WAIT_XFER: stab_d = (state_q == ST_WAIT_XFER) ? stab_nx : 8'd0;
      ST_MARK: begin
        mark_d = (state_q == ST_MARK) ? mark_q + 8'd1 : 8'd1;
        data_d = {1'b1, {PW{1'b0}}};
        vld_d  = 1'b1;
      end
      ST_STREAM: begin
        lfsr_load  = entry;
        lfsr_adv   = !entry;
        mode_d     = cur_mode;
        if (entry) num_d = num_words;
        data_d     = {1'b0, payload};
        vld_d      = 1'b1;
        word_cnt_d = (&cur_cnt) ? cur_cnt : cur_cnt + 16'd1;
        idx_d      = cur_idx + 32'd1;
        walk_d     = (cur_walk == WW'(PW-1)) ? '0 : cur_walk + WW'(1);
      end
      ST_DONE:      done_d = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      stab_q     <= '0;
      mark_q     <= '0;
      word_cnt_q <= '0;
      idx_q      <= '0;
      walk_q     <= '0;
      mode_q     <= '0;
      num_q      <= '0;
      data_q     <= '0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      stab_q     <= stab_d;
      mark_q     <= mark_d;
      word_cnt_q <= word_cnt_d;
      idx_q      <= idx_d;
      walk_q     <= walk_d;
      mode_q     <= mode_d;
      num_q      <= num_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
      rdy_q      <= rdy_d;
    end
  end

  assign ns_adapter_rstn = rdy_q;
  assign ns_mac_rdy      = rdy_q;
  assign data_in         = data_q;
  assign data_vld        = vld_q;
  assign word_cnt        = word_cnt_q;
  assign done            = done_q;
  assign state           = state_q;

endmodule
`default_nettype wire

// File: tb/tb_aib_mac_tx_gen.sv
`default_nettype none
// ============================================================================
// tb_aib_mac_tx_gen : randomized self-checking bench with a behavioural model
// Rev 1.0
// ============================================================================
module tb_aib_mac_tx_gen;

  localparam int DW    = 40;
  localparam int LOCK  = 16;
  localparam int MARKS = 8;
  localparam int BW    = 2*DW;
  localparam int PW    = BW - 1;
  localparam logic [BW-1:0] MARKER = {1'b1, {PW{1'b0}}};
  localparam logic [30:0]   SEED   = 31'h7FFF_FFFF;

  logic          clk;
  logic          rst, gen_en, ms_en, sl_en;
  logic [1:0]    gen_mode;
  logic [15:0]   num_words;
  logic          ns_adapter_rstn, ns_mac_rdy, data_vld, done;
  logic [BW-1:0] data_in;
  logic [15:0]   word_cnt;
  logic [2:0]    state;

  int errors = 0;
  int checks = 0;

  aib_mac_tx_gen #(.DWIDTH(DW), .LOCK_CYC(LOCK), .MARK_WORDS(MARKS)) dut (
    .wr_clk            (clk),
    .wr_rst            (rst),
    .gen_en            (gen_en),
    .gen_mode          (gen_mode),
    .num_words         (num_words),
    .ms_tx_transfer_en (ms_en),
    .sl_rx_transfer_en (sl_en),
    .ns_adapter_rstn   (ns_adapter_rstn),
    .ns_mac_rdy        (ns_mac_rdy),
    .data_in           (data_in),
    .data_vld          (data_vld),
    .word_cnt          (word_cnt),
    .done              (done),
    .state             (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PRBS31 reference: x^31 + x^28 + 1, newest bit enters at the LSB
  function automatic logic [30:0] ref_step(input logic [30:0] s);
    return {s[29:0], s[30] ^ s[27]};
  endfunction

  function automatic logic [BW-1:0] ref_word(input int mode, input int k, input logic [30:0] s);
    logic [PW-1:0] p;
    p = '0;
    case (mode)
      0:       p = PW'(k);
      1:       for (int i = 0; i < PW; i++) p[i] = s[i % 31];
      2:       p[k % PW] = 1'b1;
      default: p = '0;
    endcase
    return {1'b0, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From IDLE with the link up: afterwards the first stream word is visible
  task automatic start_gen(input int mode, input int n);
    gen_mode  = 2'(mode);
    num_words = 16'(n);
    ms_en = 1'b1; sl_en = 1'b1; gen_en = 1'b1;
    repeat (2 + LOCK + MARKS) tick();
  endtask

  task automatic stop_gen();
    gen_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; gen_en = 1'b0; ms_en = 1'b0; sl_en = 1'b0;
    gen_mode = 2'd0; num_words = 16'd0;
    tick(); tick();
    checks++;
    if ({data_in, data_vld, done, word_cnt, state, ns_mac_rdy, ns_adapter_rstn} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h vld=%b done=%b cnt=%0d st=%0d rdy=%b rstn=%b, all must be 0",
               data_in, data_vld, done, word_cnt, state, ns_mac_rdy, ns_adapter_rstn);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || ns_mac_rdy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: st=%0d rdy=%b, required st=0 rdy=0", state, ns_mac_rdy);
    end
  endtask

  task automatic test_bringup();
    int es;
    logic [BW-1:0] ed;
    gen_mode = 2'd0; num_words = 16'd100;
    ms_en = 1'b1; sl_en = 1'b1; gen_en = 1'b1;
    for (int c = 1; c <= 2 + LOCK + MARKS; c++) begin
      tick();
      es = (c == 1) ? 1 : (c < 2 + LOCK) ? 2 : (c < 2 + LOCK + MARKS) ? 3 : 4;
      ed = (c < 2 + LOCK) ? '0 : (c < 2 + LOCK + MARKS) ? MARKER : ref_word(0, 0, SEED);
      checks++;
      if (state !== 3'(es) || ns_mac_rdy !== 1'b1 || ns_adapter_rstn !== 1'b1) begin
        errors++;
        $display("FAIL bringup_state c=%0d: st=%0d rdy=%b rstn=%b, required st=%0d rdy=1 rstn=1",
                 c, state, ns_mac_rdy, ns_adapter_rstn, es);
      end
      checks++;
      if (data_vld !== (c >= 2 + LOCK) || data_in !== ed) begin
        errors++;
        $display("FAIL bringup_data c=%0d: vld=%b data=%h, required vld=%b data=%h",
                 c, data_vld, data_in, (c >= 2 + LOCK), ed);
      end
    end
  endtask

  // Continues from test_bringup: counter mode, 100 words, later inputs scrambled
  task automatic test_counter();
    for (int k = 0; k < 100; k++) begin
      checks++;
      if (data_in !== ref_word(0, k, SEED) || data_vld !== 1'b1 || word_cnt !== 16'(k + 1)) begin
        errors++;
        $display("FAIL counter k=%0d: data=%h vld=%b cnt=%0d, required data=%h vld=1 cnt=%0d",
                 k, data_in, data_vld, word_cnt, ref_word(0, k, SEED), k + 1);
      end
      gen_mode  = 2'($urandom);
      num_words = 16'($urandom_range(1, 50));
      tick();
    end
    for (int h = 0; h < 3; h++) begin
      checks++;
      if (done !== 1'b1 || data_vld !== 1'b0 || data_in !== '0 || word_cnt !== 16'd100 || state !== 3'd5) begin
        errors++;
        $display("FAIL counter_done h=%0d: done=%b vld=%b data=%h cnt=%0d st=%0d, required 1 0 0 100 5",
                 h, done, data_vld, data_in, word_cnt, state);
      end
      tick();
    end
    gen_en = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || done !== 1'b0 || word_cnt !== 16'd0 || ns_mac_rdy !== 1'b0) begin
      errors++;
      $display("FAIL counter_idle: st=%0d done=%b cnt=%0d rdy=%b, required 0 0 0 0",
               state, done, word_cnt, ns_mac_rdy);
    end
    tick();
  endtask

  task automatic test_prbs();
    logic [30:0] s;
    start_gen(1, 0);
    s = SEED;
    for (int k = 0; k < 10000; k++) begin
      checks++;
      if (data_in !== ref_word(1, k, s) || data_vld !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL prbs k=%0d: data=%h vld=%b done=%b, required data=%h vld=1 done=0",
                 k, data_in, data_vld, done, ref_word(1, k, s));
      end
      s = ref_step(s);
      gen_mode  = 2'($urandom);
      num_words = 16'($urandom_range(1, 20));
      tick();
    end
    stop_gen();
  endtask

  task automatic test_modes();
    int m, n;
    logic [30:0] s;
    for (int it = 0; it < 6; it++) begin
      m = (it < 4) ? it : int'($urandom_range(0, 3));
      n = (it < 4) ? int'($urandom_range(80, 200)) : (it == 4) ? 1 : int'($urandom_range(2, 10));
      start_gen(m, n);
      s = SEED;
      for (int k = 0; k < n; k++) begin
        checks++;
        if (data_in !== ref_word(m, k, s) || word_cnt !== 16'(k + 1)) begin
          errors++;
          $display("FAIL mode%0d k=%0d: data=%h cnt=%0d, required data=%h cnt=%0d",
                   m, k, data_in, word_cnt, ref_word(m, k, s), k + 1);
        end
        s = ref_step(s);
        tick();
      end
      checks++;
      if (done !== 1'b1 || data_vld !== 1'b0 || word_cnt !== 16'(n)) begin
        errors++;
        $display("FAIL mode%0d_done n=%0d: done=%b vld=%b cnt=%0d, required 1 0 %0d",
                 m, n, done, data_vld, word_cnt, n);
      end
      stop_gen();
    end
  endtask

  task automatic test_glitch(input int h);
    gen_mode = 2'd3; num_words = 16'd4;
    ms_en = 1'b1; sl_en = 1'b1; gen_en = 1'b1;
    repeat (2 + h) tick();
    sl_en = 1'b0;
    tick();
    sl_en = 1'b1;
    for (int i = 1; i < LOCK; i++) begin
      tick();
      checks++;
      if (state !== 3'd2 || data_vld !== 1'b0) begin
        errors++;
        $display("FAIL glitch_wait h=%0d i=%0d: st=%0d vld=%b, required st=2 vld=0", h, i, state, data_vld);
      end
    end
    tick();
    checks++;
    if (state !== 3'd3 || data_in !== MARKER || data_vld !== 1'b1) begin
      errors++;
      $display("FAIL glitch_mark h=%0d: st=%0d data=%h vld=%b, required st=3 data=%h vld=1",
               h, state, data_in, data_vld, MARKER);
    end
    repeat (MARKS) tick();
    checks++;
    if (state !== 3'd4 || data_in !== '0 || data_vld !== 1'b1) begin
      errors++;
      $display("FAIL glitch_stream h=%0d: st=%0d data=%h vld=%b, required st=4 data=0 vld=1",
               h, state, data_in, data_vld);
    end
    stop_gen();
  endtask

  task automatic test_link_drop();
    start_gen(0, 0);
    for (int k = 0; k < 50; k++) begin
      checks++;
      if (data_in !== ref_word(0, k, SEED)) begin
        errors++;
        $display("FAIL drop_pre k=%0d: data=%h, required %h", k, data_in, ref_word(0, k, SEED));
      end
      if (k < 49) tick();
    end
    ms_en = 1'b0;
    tick();
    checks++;
    if (data_vld !== 1'b0 || state !== 3'd2 || word_cnt !== 16'd50) begin
      errors++;
      $display("FAIL drop_edge: vld=%b st=%0d cnt=%0d, required vld=0 st=2 cnt=50", data_vld, state, word_cnt);
    end
    ms_en = 1'b1;
    for (int i = 1; i < LOCK; i++) begin
      tick();
      checks++;
      if (data_vld !== 1'b0 || state !== 3'd2) begin
        errors++;
        $display("FAIL drop_relock i=%0d: vld=%b st=%0d, required vld=0 st=2", i, data_vld, state);
      end
    end
    for (int i = 0; i < MARKS; i++) begin
      tick();
      checks++;
      if (data_in !== MARKER || state !== 3'd3) begin
        errors++;
        $display("FAIL drop_mark i=%0d: data=%h st=%0d, required %h st=3", i, data_in, state, MARKER);
      end
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (data_in !== ref_word(0, k, SEED) || word_cnt !== 16'(k + 1) || data_vld !== 1'b1) begin
        errors++;
        $display("FAIL drop_restart k=%0d: data=%h cnt=%0d vld=%b, required data=%h cnt=%0d vld=1",
                 k, data_in, word_cnt, data_vld, ref_word(0, k, SEED), k + 1);
      end
    end
    // enable removal wins over a simultaneous link drop
    ms_en = 1'b0; gen_en = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || ns_mac_rdy !== 1'b0) begin
      errors++;
      $display("FAIL drop_vs_disable: st=%0d rdy=%b, required st=0 rdy=0", state, ns_mac_rdy);
    end
    ms_en = 1'b1;
    tick();
  endtask

  task automatic test_rst_mid();
    start_gen(int'($urandom_range(0, 3)), 0);
    repeat ($urandom_range(1, 20)) tick();
    checks++;
    if (state !== 3'd4 || data_vld !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: st=%0d vld=%b, required st=4 vld=1", state, data_vld);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({data_in, data_vld, done, word_cnt, state, ns_mac_rdy, ns_adapter_rstn} !== '0) begin
      errors++;
      $display("FAIL rst_mid: data=%h vld=%b done=%b cnt=%0d st=%0d rdy=%b rstn=%b, all must be 0",
               data_in, data_vld, done, word_cnt, state, ns_mac_rdy, ns_adapter_rstn);
    end
    gen_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_gen_en_mark();
    int r;
    r = int'($urandom_range(0, MARKS - 1));
    gen_mode = 2'd0; num_words = 16'd0;
    ms_en = 1'b1; sl_en = 1'b1; gen_en = 1'b1;
    repeat (2 + LOCK + r) tick();
    checks++;
    if (state !== 3'd3 || data_in !== MARKER) begin
      errors++;
      $display("FAIL en_mark_pre r=%0d: st=%0d data=%h, required st=3 data=%h", r, state, data_in, MARKER);
    end
    gen_en = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || ns_mac_rdy !== 1'b0 || ns_adapter_rstn !== 1'b0 || data_vld !== 1'b0 || data_in !== '0) begin
      errors++;
      $display("FAIL en_mark_idle: st=%0d rdy=%b rstn=%b vld=%b data=%h, required all 0",
               state, ns_mac_rdy, ns_adapter_rstn, data_vld, data_in);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; gen_en = 1'b0; ms_en = 1'b0; sl_en = 1'b0;
    gen_mode = 2'd0; num_words = 16'd0;
    test_reset();
    test_bringup();
    test_counter();
    test_prbs();
    test_modes();
    test_glitch(10);
    test_glitch(int'($urandom_range(1, LOCK - 1)));
    test_link_drop();
    test_rst_mid();
    test_gen_en_mark();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/aib_mac_tx_gen.md
# aib_mac_tx_gen

MAC-side transmit stream generator for one AIB channel. It drives the near-side MAC bring-up signals (`ns_adapter_rstn`, `ns_mac_rdy`) and waits until both transfer enables are stable. It then sends an alignment-marker preamble followed by a deterministic payload stream on `data_in`. It feeds the adapter's TX data path and is the transmit counterpart of the MAC-side receive/align logic.

## Interface
- `DWIDTH`, 40: per-half data width; the bus is `2*DWIDTH` bits.
- `LOCK_CYC`, 16: consecutive cycles both transfer enables must be high before the preamble starts; range 1..255.
- `MARK_WORDS`, 8: number of marker words in the preamble; range 1..255.
- `wr_clk` in 1: TX write clock; the only clock.
- `wr_rst` in 1: synchronous, active-high reset.
- `gen_en` in 1: level enable. Low forces IDLE.
- `gen_mode` in 2: payload mode. 0 = counter, 1 = PRBS31, 2 = walking-one, 3 = all-zero.
- `num_words` in 16: stream length. 0 = continuous.
- `ms_tx_transfer_en` in 1: near-side TX transfer enable from the sideband.
- `sl_rx_transfer_en` in 1: far-side RX transfer enable from the sideband.
- `ns_adapter_rstn` out 1: adapter reset release.
- `ns_mac_rdy` out 1: near-side MAC ready.
- `data_in` out `2*DWIDTH`: TX word. Bit `2*DWIDTH-1` is the marker bit; the low `2*DWIDTH-1` bits are the payload.
- `data_vld` out 1: high on cycles that carry a marker or stream word.
- `word_cnt` out 16: stream words sent since the last stream start.
- `done` out 1: high in DONE.
- `state` out 3: current FSM state, for debug.

## Operation
- FSM states: IDLE=0, RDY=1, WAIT_XFER=2, MARK=3, STREAM=4, DONE=5.
- IDLE: all outputs are 0. Go to RDY when `gen_en`=1.
- RDY: `ns_adapter_rstn`=1 and `ns_mac_rdy`=1; both stay 1 in every state except IDLE. The FSM stays one cycle, then goes to WAIT_XFER.
- WAIT_XFER:
  - `xfer = ms_tx_transfer_en & sl_rx_transfer_en`.
  - An 8-bit stable counter increments while `xfer`=1 and clears when `xfer`=0.
  - When the counter reaches `LOCK_CYC`, go to MARK.
- MARK: send `MARK_WORDS` words with `data_in = {1'b1, {(2*DWIDTH-1){1'b0}}}` and `data_vld`=1, then go to STREAM.
- STREAM: marker bit = 0, `data_vld`=1, and `word_cnt` increments per word. Payload `p` (`2*DWIDTH-1` bits) by mode:
  - 0, counter: `p = word_cnt` zero-extended, where `word_cnt` is the pre-increment value.
  - 1, PRBS31: x^31+x^28+1, seed 31'h7FFF_FFFF at stream entry, one step per word. `p` = LFSR state replicated from the LSB upward and truncated.
  - 2, walking-one: `p = 1 << (word_cnt mod (2*DWIDTH-1))`.
  - 3, all-zero: `p = 0`.
- STREAM exit: when `num_words`≠0 and `word_cnt` reaches `num_words`, go to DONE. `num_words`=0 never exits by count.
- `word_cnt` saturates at 16'hFFFF; the payload keeps advancing.
- DONE: `data_vld`=0, `data_in`=0, `done`=1. The FSM holds until `gen_en`=0.
- Link drop: if `xfer`=0 in MARK or STREAM, go to WAIT_XFER in the same evaluation. `word_cnt` and the LFSR reset at the next STREAM entry, and `data_vld` drops the next cycle.
- `gen_en`=0 in any state: go to IDLE next cycle. This has priority over link drop.
- `gen_mode` and `num_words` are sampled at MARK→STREAM entry; later changes are ignored until the next entry.

## Timing
- All outputs are registered.
- Reset value of every output is 0; the FSM resets to IDLE.
- `gen_en` rise at edge N:
  - `ns_mac_rdy`=1 after edge N+1 (RDY).
  - WAIT_XFER from edge N+2.
- `xfer` high continuously from the first sampled WAIT_XFER cycle: the first marker word appears `LOCK_CYC` cycles later. It occupies exactly `MARK_WORDS` cycles, and the first stream word follows immediately with no gap cycle.
- With `num_words`=K, exactly K stream words are sent. `done` asserts the cycle after the last word.
- `wr_rst` mid-operation: all outputs are 0 after the next edge.

## Structure
- Package `aib_mac_tx_gen_pkg`:
  - state enum typedef;
  - mode localparams;
  - PRBS31 polynomial tap positions and seed.
- Sub-module `aib_prbs31_lfsr`, a single-step LFSR with ports:
  - `load` (seed);
  - `adv`;
  - `q[30:0]`.

## Test plan
- Bring-up: `gen_en`=1 with both enables already high, `LOCK_CYC`=16, `MARK_WORDS`=8 → `ns_mac_rdy` at cycle 1; 8 marker words with MSB=1 starting at cycle 18; stream from cycle 26.
- Counter, `num_words`=100 → payloads 0..99 on consecutive cycles, `word_cnt`=100, `done`=1 on the next cycle, `data_vld` then 0.
- PRBS31 continuous → first word = seed replicated; each following word matches the reference LFSR model over 10,000 words; `done` never asserts.
- Enable glitch: in WAIT_XFER, `sl_rx_transfer_en` low for one cycle after 10 high cycles → stable counter restarts and markers start 16 cycles after the re-rise.
- Link drop: `ms_tx_transfer_en`=0 after 50 stream words → `data_vld`=0 the next cycle, state=2; after re-lock, the full 8-word preamble repeats and the counter payload restarts at 0.
- Reset and enable: `wr_rst` pulse during STREAM → every output is 0 after one edge. `gen_en`=0 during MARK → IDLE next cycle, and `ns_mac_rdy`=0.
